signed_mac_accumulator: RTL and testbench

Sequential multiply-accumulate stage built around wallace_tree_multiplier_8_bit.
- Accepts a burst of signed 8-bit operand pairs over a valid/ready handshake.
- Multiplies each pair with one combinational wallace_tree_multiplier_8_bit instance, registers the 16-bit product, and adds it into a wide signed accumulator.
- Presents the dot-product result over an output valid/ready handshake.

---
 rtl/signed_mac_accumulator.sv | 253 +++++++++++++++++++++++++
 tb/tb_signed_mac_accumulator.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_mac_accumulator.sv
// signed_mac_accumulator: burst multiply-accumulate stage.
//
// Signed 8-bit operand pairs are accepted over a valid/ready handshake. Each
// pair is multiplied by a combinational Wallace-tree multiplier. The 16-bit
// product is registered, then sign-extended and added into an ACC_W-bit
// accumulator. The final dot product is offered on an output valid/ready
// handshake.
//
// Optional build macro SIGNED_MAC_SATURATE_EN:
//   - Defined: every addition clamps at the signed ACC_W limits, and the
//     sticky ovf flag records any clamp.
//   - Undefined: the accumulation wraps and ovf is tied low.

// 8x8 signed multiplier. Rows are reduced with a carry-save (3:2) tree and
// finished with one carry-propagate add.
//
// The multiplicand is sign-extended to 16 bits. Rows 0..6 are the ordinary
// shifted partial products. The multiplier's sign bit has weight -2^7, so
// that row is negated: its bits are inverted, and the +1 of the two's
// complement negation is a separate single-bit row. Everything is exact
// modulo 2^16, which covers the whole product range.
module wallace_tree_multiplier_8_bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] sa;
    logic [15:0] pp [0:8];
    logic [15:0] s0, c0, s1, c1, s2, c2;
    logic [15:0] s3, c3, s4, c4;
    logic [15:0] s5, c5, s6, c6;

    function automatic logic [15:0] csa_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [15:0] csa_carry(input logic [15:0] x, input logic [15:0] y,
                                              input logic [15:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    assign sa = {{8{a[7]}}, a};

    // Partial product generation, including the negated sign row and its +1
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            pp[i] = b[i] ? (sa << i) : 16'd0;
        end
        pp[7] = b[7] ? ~(sa << 7) : 16'd0;
        pp[8] = {15'd0, b[7]};
    end

    // Level 1: 9 rows -> 6 rows
    assign s0 = csa_sum  (pp[0], pp[1], pp[2]);
    assign c0 = csa_carry(pp[0], pp[1], pp[2]);
    assign s1 = csa_sum  (pp[3], pp[4], pp[5]);
    assign c1 = csa_carry(pp[3], pp[4], pp[5]);
    assign s2 = csa_sum  (pp[6], pp[7], pp[8]);
    assign c2 = csa_carry(pp[6], pp[7], pp[8]);

    // Level 2: 6 rows -> 4 rows
    assign s3 = csa_sum  (s0, c0, s1);
    assign c3 = csa_carry(s0, c0, s1);
    assign s4 = csa_sum  (c1, s2, c2);
    assign c4 = csa_carry(c1, s2, c2);

    // Level 3: 4 rows -> 3 rows
    assign s5 = csa_sum  (s3, c3, s4);
    assign c5 = csa_carry(s3, c3, s4);

    // Level 4: 3 rows -> 2 rows
    assign s6 = csa_sum  (s5, c5, c4);
    assign c6 = csa_carry(s5, c5, c4);

    // Final carry-propagate addition
    assign p = s6 + c6;
endmodule

// Handshake rules, applying to both ports:
//   - A transfer happens on a rising edge where valid && ready.
//   - in_ready does not depend on in_valid.
//   - out_valid does not depend on out_ready.
//   - Once out_valid rises, it and acc_out hold until the edge on which
//     out_ready is seen high.
module signed_mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       X_in,
    input  logic [7:0]       Y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [15:0]      prod;
    logic [15:0]      prod_q;
    logic             prod_v;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic             start_ok;
    logic             xfer;
    logic             last_xfer;

    wallace_tree_multiplier_8_bit u_mult (
        .a (X_in),
        .b (Y_in),
        .p (prod)
    );

    // start is only honoured in IDLE; a pair moves only while RUN is short of len
    assign start_ok  = (state == IDLE) && start;
    assign in_ready  = (state == RUN) && (count < len_q);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (count == (len_q - LEN_ONE));

    assign prod_ext  = ACC_W'($signed(prod_q));

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign acc_out   = acc;
    assign dbg_state = state;

`ifdef SIGNED_MAC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide_sum;
    logic           clamp;
    logic           ovf_q;

    // One guard bit above the accumulator. Overflow shows up as the guard
    // bit disagreeing with the result's sign bit; the guard bit gives the
    // true sign of the sum.
    assign wide_sum = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};

    // Clamp the addition result to the signed limits on overflow
    always_comb begin
        acc_sum = wide_sum[ACC_W-1:0];
        clamp   = 1'b0;
        if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
            clamp   = 1'b1;
            acc_sum = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Sticky overflow flag: cleared by an accepted start, set by any clamp
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            ovf_q <= 1'b0;
        end else if (prod_v && clamp) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    // Plain modulo-2^ACC_W accumulation
    assign acc_sum = acc + prod_ext;
    assign ovf     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN always holds the last registered product, so
    // it lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_xfer) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // The product is captured on the transfer edge and added to the
    // accumulator on the following edge. A gap in in_valid leaves prod_v low,
    // so the accumulator and the count simply hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q  <= '0;
            count  <= '0;
            prod_q <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else if (start_ok) begin
            len_q  <= len;
            count  <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            if (xfer) begin
                count  <= count + LEN_ONE;
                prod_q <= prod;
            end
            prod_v <= xfer;
            if (prod_v) begin
                acc <= acc_sum;
            end
        end
    end
endmodule

// File: tb/tb_signed_mac_accumulator.sv
// Bench for signed_mac_accumulator.
//
// Two instances, one with ACC_W=24 and one with ACC_W=16, receive identical
// stimulus. Expected results come from a plain-integer dot-product model
// that either wraps or clamps at each addition, depending on
// SIGNED_MAC_SATURATE_EN.
module tb_signed_mac_accumulator;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [7:0]  X_in;
    logic [7:0]  Y_in;
    logic        out_ready;

    logic        rdy24, ov24, busy24, ovf24;
    logic [23:0] acc24;
    logic [1:0]  dbg24;
    logic        rdy16, ov16, busy16, ovf16;
    logic [15:0] acc16;
    logic [1:0]  dbg16;

    int total = 0;
    int bad   = 0;

`ifdef SIGNED_MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Scoreboard: expected results per burst, pushed before the burst runs
    logic [23:0] exp_q[$];
    logic [15:0] exp16_q[$];
    logic [1:0]  expov_q[$];

    int px[0:255];
    int py[0:255];

    // Observations gathered by run_burst for the scenario tasks to judge
    logic [23:0] obs_a24;
    logic [15:0] obs_a16;
    logic        obs_o24, obs_o16;
    int          obs_lat;
    bit          obs_to;
    bit          obs_held_ok;
    bit          obs_rdy_seen;
    bit          obs_rdy_after;
    bit          obs_after;

    signed_mac_accumulator #(.ACC_W(24), .LEN_W(8)) u_dut24 (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(rdy24), .X_in(X_in), .Y_in(Y_in),
        .out_valid(ov24), .out_ready(out_ready), .acc_out(acc24),
        .busy(busy24), .ovf(ovf24), .dbg_state(dbg24)
    );

    signed_mac_accumulator #(.ACC_W(16), .LEN_W(8)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(rdy16), .X_in(X_in), .Y_in(Y_in),
        .out_valid(ov16), .out_ready(out_ready), .acc_out(acc16),
        .busy(busy16), .ovf(ovf16), .dbg_state(dbg16)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain dot product, with per-step wrap or clamp to w bits
    function automatic longint model_acc(input int w, input int n, output bit ov);
        longint acc, span, mx, mn;
        span = longint'(1) <<< w;
        mx   = span / 2 - 1;
        mn   = -(span / 2);
        acc  = 0;
        ov   = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = acc + longint'(px[i] * py[i]);
            if (SAT) begin
                if (acc > mx) begin
                    acc = mx;
                    ov  = 1'b1;
                end else if (acc < mn) begin
                    acc = mn;
                    ov  = 1'b1;
                end
            end else begin
                if (acc > mx) acc = acc - span;
                else if (acc < mn) acc = acc + span;
            end
        end
        return acc;
    endfunction

    task automatic push_expect(input int n);
        longint e24, e16;
        bit     o24, o16;
        e24 = model_acc(24, n, o24);
        e16 = model_acc(16, n, o16);
        exp_q.push_back(e24[23:0]);
        exp16_q.push_back(e16[15:0]);
        expov_q.push_back({o24, o16});
    endtask

    // Driver: start a burst of n pairs from px/py, insert gaps, wait for the
    // result, hold out_ready low for 'hold' cycles (optionally poking start
    // and in_valid), then accept the result.
    task automatic run_burst(input int n, input int gmin, input int gmax,
                             input int hold, input bit poke);
        int w;
        int g;
        obs_to        = 1'b0;
        obs_lat       = -1;
        obs_held_ok   = 1'b1;
        obs_rdy_after = 1'b0;
        obs_rdy_seen  = rdy24 | rdy16;
        start = 1'b1;
        len   = 8'(n);
        tick;
        start = 1'b0;
        len   = 8'($urandom_range(0, 255));
        obs_rdy_seen = obs_rdy_seen | ((n == 0) ? (rdy24 | rdy16) : 1'b0);
        if (n == 0) obs_lat = 1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                g = $urandom_range(gmin, gmax);
                repeat (g) begin
                    in_valid = 1'b0;
                    X_in     = 8'($urandom_range(0, 255));
                    tick;
                end
            end
            X_in     = px[i][7:0];
            Y_in     = py[i][7:0];
            in_valid = 1'b1;
            w = 0;
            while (rdy24 !== 1'b1 && w < 20) begin
                tick;
                w++;
            end
            if (w >= 20) begin
                obs_to   = 1'b1;
                in_valid = 1'b0;
                return;
            end
            tick;
            in_valid = 1'b0;
            X_in     = 8'($urandom_range(0, 255));
            Y_in     = 8'($urandom_range(0, 255));
            len      = 8'($urandom_range(0, 255));
            obs_lat  = 1;
            if (i == n - 1) obs_rdy_after = rdy24 | rdy16;
        end
        w = 0;
        while (!(ov24 === 1'b1 && ov16 === 1'b1) && w < 20) begin
            if (n == 0) obs_rdy_seen = obs_rdy_seen | rdy24 | rdy16;
            tick;
            w++;
            obs_lat++;
        end
        if (w >= 20) begin
            obs_to = 1'b1;
            return;
        end
        obs_a24 = acc24;
        obs_a16 = acc16;
        obs_o24 = ovf24;
        obs_o16 = ovf16;
        for (int h = 0; h < hold; h++) begin
            start    = poke;
            in_valid = poke;
            len      = 8'd5;
            X_in     = 8'($urandom_range(0, 255));
            tick;
            if (ov24 !== 1'b1 || ov16 !== 1'b1 || rdy24 !== 1'b0 || rdy16 !== 1'b0 ||
                acc24 !== exp_q[0] || acc16 !== exp16_q[0]) obs_held_ok = 1'b0;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        obs_after = ov24 | ov16 | busy24 | busy16;
    endtask

    task automatic test_reset;
        total++;
        if ({acc24, acc16} !== 40'd0) begin
            bad++;
            $display("FAIL reset_acc: got %h/%h want 0/0", acc24, acc16);
        end
        total++;
        if ({rdy24, ov24, busy24, ovf24, rdy16, ov16, busy16, ovf16} !== 8'd0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {rdy24, ov24, busy24, ovf24, rdy16, ov16, busy16, ovf16});
        end
    endtask

    task automatic test_basic;
        logic [23:0] e24;
        logic [15:0] e16;
        logic [1:0]  eo;
        px[0] = -74;  py[0] = -99;
        px[1] = 127;  py[1] = 127;
        px[2] = -128; py[2] = 127;
        push_expect(3);
        run_burst(3, 0, 0, 0, 1'b0);
        e24 = exp_q.pop_front();
        e16 = exp16_q.pop_front();
        eo  = expov_q.pop_front();
        total++;
        if (obs_to) begin bad++; $display("FAIL basic_timeout: got timeout want result"); end
        total++;
        if (obs_a24 !== 24'd7199) begin
            bad++; $display("FAIL basic_const: got %0d want 7199", $signed(obs_a24));
        end
        total++;
        if (obs_a24 !== e24 || obs_a16 !== e16) begin
            bad++;
            $display("FAIL basic_acc: got %0d/%0d want %0d/%0d",
                     $signed(obs_a24), $signed(obs_a16), $signed(e24), $signed(e16));
        end
        total++;
        if ({obs_o24, obs_o16} !== eo) begin
            bad++; $display("FAIL basic_ovf: got %b want %b", {obs_o24, obs_o16}, eo);
        end
        total++;
        if (obs_lat !== 2) begin bad++; $display("FAIL basic_latency: got %0d want 2", obs_lat); end
        total++;
        if (obs_rdy_after !== 1'b0) begin
            bad++; $display("FAIL basic_ready_drop: got %b want 0", obs_rdy_after);
        end
        total++;
        if (obs_after !== 1'b0) begin
            bad++; $display("FAIL basic_idle: got %b want 0", obs_after);
        end
    endtask

    task automatic test_backpressure;
        logic [23:0] e24;
        logic [15:0] e16;
        logic [1:0]  eo;
        px[0] = -74;  py[0] = -99;
        px[1] = 127;  py[1] = 127;
        px[2] = -128; py[2] = 127;
        push_expect(3);
        run_burst(3, 2, 2, 5, 1'b0);
        e24 = exp_q.pop_front();
        e16 = exp16_q.pop_front();
        eo  = expov_q.pop_front();
        total++;
        if (obs_to || obs_a24 !== e24 || obs_a16 !== e16) begin
            bad++;
            $display("FAIL bp_acc: got %0d/%0d want %0d/%0d (timeout=%0b)",
                     $signed(obs_a24), $signed(obs_a16), $signed(e24), $signed(e16), obs_to);
        end
        total++;
        if ({obs_o24, obs_o16} !== eo) begin
            bad++; $display("FAIL bp_ovf: got %b want %b", {obs_o24, obs_o16}, eo);
        end
        total++;
        if (obs_held_ok !== 1'b1) begin
            bad++; $display("FAIL bp_hold: got unstable result want held");
        end
        total++;
        if (obs_lat !== 2) begin bad++; $display("FAIL bp_latency: got %0d want 2", obs_lat); end
        total++;
        if (obs_after !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b want 0", obs_after); end
    endtask

    task automatic test_zero_len;
        logic [23:0] e24;
        logic [15:0] e16;
        logic [1:0]  eo;
        push_expect(0);
        run_burst(0, 0, 0, 2, 1'b0);
        e24 = exp_q.pop_front();
        e16 = exp16_q.pop_front();
        eo  = expov_q.pop_front();
        total++;
        if (obs_to || obs_a24 !== e24 || obs_a16 !== e16 || {obs_o24, obs_o16} !== eo) begin
            bad++;
            $display("FAIL zero_acc: got %0d/%0d ovf %b want %0d/%0d ovf %b",
                     $signed(obs_a24), $signed(obs_a16), {obs_o24, obs_o16},
                     $signed(e24), $signed(e16), eo);
        end
        total++;
        if (obs_lat !== 1) begin bad++; $display("FAIL zero_latency: got %0d want 1", obs_lat); end
        total++;
        if (obs_rdy_seen !== 1'b0) begin bad++; $display("FAIL zero_ready: got 1 want 0"); end
        total++;
        if (obs_after !== 1'b0) begin bad++; $display("FAIL zero_idle: got %b want 0", obs_after); end
    endtask

    task automatic test_overflow;
        logic [23:0] e24;
        logic [15:0] e16;
        logic [1:0]  eo;
        logic [15:0] c16;
        for (int i = 0; i < 3; i++) begin
            px[i] = -128;
            py[i] = -128;
        end
        push_expect(3);
        run_burst(3, 0, 1, 1, 1'b0);
        e24 = exp_q.pop_front();
        e16 = exp16_q.pop_front();
        eo  = expov_q.pop_front();
        c16 = SAT ? 16'h7FFF : 16'hC000;
        total++;
        if (obs_to || obs_a16 !== c16 || obs_a16 !== e16) begin
            bad++;
            $display("FAIL ovf_acc16: got %0d want %0d", $signed(obs_a16), $signed(c16));
        end
        total++;
        if (obs_a24 !== 24'd49152 || obs_a24 !== e24) begin
            bad++; $display("FAIL ovf_acc24: got %0d want 49152", $signed(obs_a24));
        end
        total++;
        if ({obs_o24, obs_o16} !== eo || obs_o16 !== SAT) begin
            bad++; $display("FAIL ovf_flag: got %b want %b", {obs_o24, obs_o16}, eo);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        logic [23:0] e24;
        logic [15:0] e16;
        logic [1:0]  eo;
        start = 1'b1;
        len   = 8'd4;
        tick;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            X_in     = 8'($urandom_range(0, 255));
            Y_in     = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            w = 0;
            while (rdy24 !== 1'b1 && w < 20) begin
                tick;
                w++;
            end
            tick;
        end
        in_valid = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        total++;
        if ({acc24, acc16} !== 40'd0) begin
            bad++; $display("FAIL midreset_acc: got %h/%h want 0/0", acc24, acc16);
        end
        total++;
        if ({rdy24, ov24, busy24, ovf24, rdy16, ov16, busy16, ovf16} !== 8'd0) begin
            bad++;
            $display("FAIL midreset_flags: got %b want 00000000",
                     {rdy24, ov24, busy24, ovf24, rdy16, ov16, busy16, ovf16});
        end
        #2 reset_n = 1'b1;
        tick;
        px[0] = 3;
        py[0] = -5;
        push_expect(1);
        run_burst(1, 0, 0, 0, 1'b0);
        e24 = exp_q.pop_front();
        e16 = exp16_q.pop_front();
        eo  = expov_q.pop_front();
        total++;
        if (obs_to || obs_a24 !== 24'hFFFFF1 || obs_a24 !== e24 || obs_a16 !== e16) begin
            bad++;
            $display("FAIL midreset_after: got %0d/%0d want -15/%0d",
                     $signed(obs_a24), $signed(obs_a16), $signed(e16));
        end
        total++;
        if ({obs_o24, obs_o16} !== eo) begin
            bad++; $display("FAIL midreset_ovf: got %b want %b", {obs_o24, obs_o16}, eo);
        end
    endtask

    task automatic test_ignored;
        logic [23:0] e24;
        logic [15:0] e16;
        logic [1:0]  eo;
        px[0] = 100; py[0] = -77;
        px[1] = -9;  py[1] = 45;
        push_expect(2);
        run_burst(2, 0, 0, 4, 1'b1);
        e24 = exp_q.pop_front();
        e16 = exp16_q.pop_front();
        eo  = expov_q.pop_front();
        total++;
        if (obs_to || obs_a24 !== e24 || obs_a16 !== e16 || {obs_o24, obs_o16} !== eo) begin
            bad++;
            $display("FAIL ignored_acc: got %0d/%0d want %0d/%0d",
                     $signed(obs_a24), $signed(obs_a16), $signed(e24), $signed(e16));
        end
        total++;
        if (obs_held_ok !== 1'b1) begin
            bad++; $display("FAIL ignored_hold: got state change want none");
        end
        total++;
        if (obs_after !== 1'b0) begin bad++; $display("FAIL ignored_idle: got %b want 0", obs_after); end
    endtask

    task automatic test_random;
        int n;
        logic [23:0] e24;
        logic [15:0] e16;
        logic [1:0]  eo;
        for (int b = 0; b < 12; b++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    px[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
                    py[i] = ($urandom_range(0, 1) == 1) ? 127 : -128;
                end else begin
                    px[i] = int'($urandom_range(0, 255)) - 128;
                    py[i] = int'($urandom_range(0, 255)) - 128;
                end
            end
            push_expect(n);
            run_burst(n, 0, 2, $urandom_range(0, 3), 1'b0);
            e24 = exp_q.pop_front();
            e16 = exp16_q.pop_front();
            eo  = expov_q.pop_front();
            total++;
            if (obs_to || obs_a24 !== e24 || obs_a16 !== e16) begin
                bad++;
                $display("FAIL random_acc[%0d]: got %0d/%0d want %0d/%0d", b,
                         $signed(obs_a24), $signed(obs_a16), $signed(e24), $signed(e16));
            end
            total++;
            if ({obs_o24, obs_o16} !== eo || obs_lat !== 2) begin
                bad++;
                $display("FAIL random_ovf_lat[%0d]: got ovf %b lat %0d want ovf %b lat 2", b,
                         {obs_o24, obs_o16}, obs_lat, eo);
            end
        end
    endtask

    // Reset, then the scenarios in sequence, then the report
    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        X_in      = 8'd0;
        Y_in      = 8'd0;
        out_ready = 1'b0;
        repeat (2) tick;
        test_reset;
        reset_n = 1'b1;
        tick;
        test_basic;
        test_backpressure;
        test_zero_len;
        test_overflow;
        test_reset_mid;
        test_ignored;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
